stepper_seq_ctrl: RTL
=====================

Name: stepper_seq_ctrl

Overview:
- Avalon-MM slave that sequences a 4-coil unipolar stepper motor.
- Replaces direct software bit-banging of the 4-bit motor PIO.
- Generates full-step or half-step coil patterns at a programmable step period, in either direction, for a programmed step count or continuously.
- Sits on the NIOS data bus; drives the motor driver pins directly.

Parameters:
- PERIOD_W, 24, width of step-period register (clocks per step).
- STEP_W, 16, width of step-count register.
- DEFAULT_PERIOD, 50000, PERIOD reset value (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero wait states, combinational from address.
- coils  out  4  coil drive, bit0 = coil A … bit3 = coil D.
- irq  out  1  done interrupt (STEPPER_IRQ_EN only; tied 0 otherwise).

Behaviour:
Clock and reset:
- One clock, clk.
- Reset is asynchronous and active-high, port reset.

Register map (write = chipselect & ~write_n):
- addr0 CTRL:
  - [0] run: write 1 starts; write 0 stops.
  - [1] dir: 1 = phase index increments.
  - [2] half: 1 = half-step.
  - [3] hold: coils stay energised when idle.
  - Read returns {hold, half, dir, busy}.
- addr1 PERIOD:
  - [PERIOD_W-1:0] clocks per step.
  - Written values <2 are stored as 2.
- addr2 STEPS:
  - Write sets the remaining count; 0 = continuous.
  - Read returns the live remaining count.
- addr3 STATUS:
  - [0] busy, [1] done (sticky), [10:8] phase index.
  - Writing bit1=1 clears done; other bits read-only.
- Unused read bits are 0.

Phase table, idx 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Half mode: idx ±1 mod 8.
- Full mode: if idx is odd, idx ±2 mod 8; if idx is even, idx ±1 (aligns to a two-coil pattern).

FSM states: IDLE, RUN.
- IDLE -> RUN: write CTRL with run=1.
  - Timer loads PERIOD; busy=1 the following cycle.
- RUN, each step:
  - Timer decrements each cycle.
  - When timer==1: idx advances, timer reloads PERIOD, remaining decrements if nonzero.
  - The coils change on the clock edge after the expiry cycle.
  - The first step lands PERIOD cycles after the start write.
- RUN -> IDLE, count exhausted: the step that takes remaining 1->0 returns to IDLE and sets done in the same edge.
- RUN -> IDLE, stop: write CTRL with run=0.
  - IDLE next cycle; idx retained; done not set; remaining retained.
- Start with STEPS=0: runs continuously until stopped.

Updates while in RUN:
- Writes to dir/half take effect at the next step.
- A PERIOD write takes effect at the next reload; the current interval is not cut short.
- A STEPS write reloads remaining immediately; writing 0 switches to continuous.
- A CTRL write with run=1 while busy updates the fields only; the timer is not restarted.

Simultaneous events:
- Final step and stop write in the same cycle: the step completes and done is set.
- done set and done-clear in the same cycle: set wins.

Coil output:
- RUN, or IDLE with hold=1: coils = table[idx], registered.
- IDLE with hold=0: coils = 0000.

Reset values:
- state IDLE, idx 0, coils 0000, CTRL fields 0.
- PERIOD = DEFAULT_PERIOD, STEPS 0, done 0, irq 0.
- Reset mid-run aborts immediately with no glitch beyond the asynchronous clear.

Optional Feature:
- Macro STEPPER_IRQ_EN.
- Defined:
  - CTRL[4] irq_en is added (readable at CTRL[4]).
  - irq = done & irq_en, registered, level-sensitive.
  - irq clears when done is cleared.
- Undefined:
  - CTRL[4] reads 0 and ignores writes.
  - irq is tied to 0.

Decomposition:
- Shared package stepper_pkg holds:
  - register address constants (CTRL=0, PERIOD=1, STEPS=2, STATUS=3);
  - CTRL/STATUS bit positions;
  - the 8-entry phase table;
  - the FSM state enum.
- One natural sub-module, stepper_step_timer: period counter with reload and expiry pulse.

Test Plan:
- Reset -> coils=0000, readdata of PERIOD = 50000, STATUS = 0.
- PERIOD=4, STEPS=3, CTRL=0b0011 (half=0, dir=1, run=1) from idx 0:
  - idx sequence 1, 3, 5; coils 0011, 0110, 1100 at cycles 4, 8, 12 after the write;
  - busy drops and done=1 after the 3rd step; coils hold 0000 since hold=0.
- Half, dir=0, STEPS=2, from idx 0 -> idx 7 then 6, coils 1001 then 1000.
- STEPS=0 continuous run, PERIOD=2, stop after 10 steps -> busy=0, done=0, idx=(start+10) mod 8 in half mode, hold=1 keeps that pattern.
- PERIOD write of 1 -> reads back 2; PERIOD change mid-run applies only after the current interval completes.
- Done clear racing the final step -> done remains 1; with STEPPER_IRQ_EN and irq_en=1, irq rises 1 cycle after done and falls after a W1C to STATUS[1].

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer: register addresses,
// CTRL/STATUS bit positions, the 8-entry coil phase table, FSM state enum
// and the phase-advance helper.
package stepper_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_STEPS  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_HALF   = 2;
    localparam int CTRL_HOLD   = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_IDX  = 8;

    // Odd entries energise two adjacent coils, even entries a single coil.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Full-step mode walks the odd (two-coil) entries; from an even entry
    // the first move is a single index to land on a two-coil pattern.
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
        logic [2:0] delta;
        delta = (half || !idx[0]) ? 3'd1 : 3'd2;
        return dir ? idx + delta : idx - delta;
    endfunction

endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// Avalon-MM slave bus bundle for the stepper sequencer.
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data (zero wait states, combinational from address)
interface stepper_seq_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata,
                    input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata);
endinterface

// File: rtl/stepper_step_timer.sv
// Step period counter.
//   load   : load the counter with period (start of a run)
//   enable : count down while running
//   period : clocks per step
//   expire : one-cycle pulse in the last cycle of each interval; the counter
//            reloads period on the same edge so intervals run back to back.
module stepper_step_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    assign expire = enable && !load && (cnt_q == PERIOD_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load || expire)
            cnt_d = period;
        else if (enable)
            cnt_d = cnt_q - PERIOD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Avalon-MM stepper motor sequencer for a 4-coil unipolar motor.
// Generates full/half-step coil patterns at a programmable period, either
// direction, for a step count or continuously.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : Avalon-MM slave (CTRL, PERIOD, STEPS, STATUS registers)
//   coils      : registered coil drive, bit0 = coil A .. bit3 = coil D
//   irq        : done interrupt
// Optional feature macro STEPPER_IRQ_EN: adds CTRL[4] irq_en and drives
// irq = done & irq_en (registered); without it CTRL[4] reads 0 and irq is 0.
module stepper_seq_ctrl
    import stepper_pkg::*;
#(
    parameter int PERIOD_W       = 24,
    parameter int STEP_W         = 16,
    parameter int DEFAULT_PERIOD = 50000
) (
    input  logic                clk,
    input  logic                reset,
    stepper_seq_ctrl_if.slave   bus,
    output logic [3:0]          coils,
    output logic                irq
);

    state_e              state_q, state_d;
    logic                dir_q, dir_d, half_q, half_d, hold_q, hold_d;
    logic                irq_en_q, irq_en_d, done_q, done_d, irq_q, irq_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          coils_q, coils_d;

    logic        wr, wr_ctrl, wr_period, wr_steps, wr_status;
    logic        busy, start, step;
    logic [31:0] wd;
    logic        unused_wd;

    assign wd        = bus.writedata;
    assign unused_wd = &{1'b0, wd[31:PERIOD_W]};
    assign wr        = bus.chipselect && !bus.write_n;
    assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
    assign wr_period = wr && (bus.address == ADDR_PERIOD);
    assign wr_steps  = wr && (bus.address == ADDR_STEPS);
    assign wr_status = wr && (bus.address == ADDR_STATUS);
    assign busy      = (state_q == S_RUN);
    // A run=1 write while busy only updates fields; the timer keeps going.
    assign start     = wr_ctrl && wd[CTRL_RUN] && !busy;

    stepper_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst    (reset),
        .load   (start),
        .enable (busy),
        .period (period_q),
        .expire (step)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        half_d   = half_q;
        hold_d   = hold_q;
        period_d = period_q;
        steps_d  = steps_q;
        idx_d    = idx_q;
        done_d   = done_q;

        if (wr_ctrl) begin
            dir_d  = wd[CTRL_DIR];
            half_d = wd[CTRL_HALF];
            hold_d = wd[CTRL_HOLD];
        end
`ifdef STEPPER_IRQ_EN
        irq_en_d = wr_ctrl ? wd[CTRL_IRQ_EN] : irq_en_q;
        irq_d    = done_q && irq_en_q;
`else
        irq_en_d = 1'b0;
        irq_d    = 1'b0;
`endif
        if (wr_period)
            period_d = (wd[PERIOD_W-1:0] < PERIOD_W'(2)) ? PERIOD_W'(2) : wd[PERIOD_W-1:0];

        // The step uses the dir/half in force before any same-cycle write.
        if (step) begin
            idx_d = next_idx(idx_q, dir_q, half_q);
            if (steps_q != '0)
                steps_d = steps_q - STEP_W'(1);
        end
        if (wr_steps)
            steps_d = wd[STEP_W-1:0];

        // Clear first so a same-cycle completion wins.
        if (wr_status && wd[STAT_DONE])
            done_d = 1'b0;

        if (!busy) begin
            if (start)
                state_d = S_RUN;
        end else if (step && (steps_q == STEP_W'(1)) && !wr_steps) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else if (wr_ctrl && !wd[CTRL_RUN]) begin
            state_d = S_IDLE;
        end

        // Energise from the start edge; the step that ends a run is still
        // driven for one cycle before the coils drop (when hold=0).
        coils_d = (busy || (state_d == S_RUN) || hold_q) ? PHASE_TABLE[idx_d] : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            half_q   <= 1'b0;
            hold_q   <= 1'b0;
            irq_en_q <= 1'b0;
            period_q <= PERIOD_W'(DEFAULT_PERIOD);
            steps_q  <= '0;
            idx_q    <= 3'd0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            coils_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            half_q   <= half_d;
            hold_q   <= hold_d;
            irq_en_q <= irq_en_d;
            period_q <= period_d;
            steps_q  <= steps_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            coils_q  <= coils_d;
        end
    end

    assign coils = coils_q;
    assign irq   = irq_q;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                bus.readdata[STAT_BUSY]   = busy;
                bus.readdata[CTRL_DIR]    = dir_q;
                bus.readdata[CTRL_HALF]   = half_q;
                bus.readdata[CTRL_HOLD]   = hold_q;
                bus.readdata[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_PERIOD: bus.readdata[PERIOD_W-1:0] = period_q;
            ADDR_STEPS:  bus.readdata[STEP_W-1:0]   = steps_q;
            default: begin
                bus.readdata[STAT_BUSY]            = busy;
                bus.readdata[STAT_DONE]            = done_q;
                bus.readdata[STAT_IDX+2:STAT_IDX]  = idx_q;
            end
        endcase
    end

endmodule
